// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default framing constants.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DBIT       = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to 1 (idle line).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch rejection, optional parity, stop-bit framing check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = UART_DBIT,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned SB_TICK    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            parity_en,
  input  logic            parity_odd,
  output logic [DBIT-1:0] dout,
  output logic            rx_done,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE * 2);
  localparam int unsigned BW = $clog2(DBIT + 1);

  localparam logic [TW-1:0] HalfLast = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BitLast  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] StopLast = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DataLast = BW'(DBIT - 1);

  logic rx_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_state_e     state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            par_en_q, par_en_d;
  logic            par_odd_q, par_odd_d;
  logic            par_bit_q, par_bit_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_err_q, parity_err_d;
  logic            rx_done_q, rx_done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      dout_q       <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      rx_done_q    <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      par_bit_q    <= par_bit_d;
      dout_q       <= dout_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      rx_done_q    <= rx_done_d;
    end
  end

  // Only IDLE reacts without s_tick, so a start edge is caught in any clk cycle.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    par_bit_d    = par_bit_q;
    dout_d       = dout_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    rx_done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (tick_q == HalfLast) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d   = StData;
              bit_d     = '0;
              par_en_d  = parity_en;
              par_odd_d = parity_odd;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (tick_q == BitLast) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DBIT-1:1]};
            if (bit_q == DataLast) begin
              bit_d   = '0;
              state_d = par_en_q ? StParity : StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (s_tick) begin
          if (tick_q == BitLast) begin
            tick_d    = '0;
            par_bit_d = rx_s;
            state_d   = StStop;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (tick_q == StopLast) begin
            tick_d       = '0;
            state_d      = StIdle;
            rx_done_d    = 1'b1;
            dout_d       = shift_q;
            frame_err_d  = ~rx_s;
            parity_err_d = par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    dout       = dout_q;
    rx_done    = rx_done_q;
    frame_err  = frame_err_q;
    parity_err = parity_err_q;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame (5..9).
REQ-002 Parameter OVERSAMPLE, default 16, s_tick pulses per bit period.
REQ-003 Parameter SB_TICK, default 16, s_tick pulses spent in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 s_tick  input  1  one-clk-wide oversampling pulse from the baud rate generator bclk output.
REQ-007 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-008 parity_en  input  1  1 = one parity bit follows the data bits.
REQ-009 parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en=0.
REQ-010 dout  output  DBIT  last received data word, LSB first on the line.
REQ-011 rx_done  output  1  one-clk pulse, dout/frame_err/parity_err valid.
REQ-012 frame_err  output  1  stop bit sampled low in the last frame.
REQ-013 parity_err  output  1  parity mismatch in the last frame; 0 when parity disabled.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 rx SHALL pass a 2-flop synchroniser (both flops reset to 1) before any use; all later references to rx mean the synchronised value.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; tick counter clog2(OVERSAMPLE*2) bits, bit counter clog2(DBIT+1) bits.
REQ-017 Counters and state SHALL advance only in clk cycles where s_tick=1, except the IDLE->START transition.
REQ-018 IDLE: rx=0 in any clk cycle -> START, tick counter cleared.
REQ-019 START: on the tick where tick counter = OVERSAMPLE/2-1, rx=0 -> DATA with both counters cleared; rx=1 -> IDLE (glitch rejected, no rx_done).
REQ-020 START: parity_en and parity_odd SHALL be latched on confirmation of the start bit and held for the frame.
REQ-021 DATA: on the tick where tick counter = OVERSAMPLE-1, rx shifts into the MSB of a DBIT shift register (right shift) and the counter clears; after DBIT samples -> PARITY if latched parity_en, else STOP.
REQ-022 PARITY: sample rx at tick OVERSAMPLE-1; error = (XOR of data bits XOR sampled bit) != latched parity_odd; -> STOP.
REQ-023 STOP: on the tick where tick counter = SB_TICK-1, sample rx; in the following clk edge dout, frame_err (=~rx), parity_err update, rx_done=1 for exactly one clk, state -> IDLE.
REQ-024 dout, frame_err, parity_err SHALL hold their values until the next rx_done.
REQ-025 A falling edge of rx in the clk cycle after leaving STOP SHALL start a new frame (back-to-back frames, no idle gap needed).
REQ-026 A frame with frame_err=1 SHALL still deliver dout and rx_done.
REQ-027 Latency: rx_done asserts (OVERSAMPLE/2 + DBIT*OVERSAMPLE + parity_en*OVERSAMPLE + SB_TICK) ticks after start detection, plus 2-3 clk for synchronisation and output registering.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, counters 0, shift register 0, dout=0, rx_done=0, frame_err=0, parity_err=0, busy=0, synchroniser flops=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no rx_done; after release the block SHALL wait in IDLE for the next falling edge.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state enumeration and the OVERSAMPLE and default DBIT constants, for reuse by the transmitter.
REQ-031 One sub-module, sync_2ff, SHALL implement the rx synchroniser; everything else is contained in uart_rx.

Verification
REQ-032 Bench drives s_tick from the baud rate generator with div=10 (tick every 10 clk, bit = 160 clk), clk period 10 ns.
REQ-033 Frame 0x55, parity off, 1 stop -> dout=0x55, single-cycle rx_done about 1520 clk after the start edge, frame_err=0, parity_err=0.
REQ-034 Frame 0xA3, even parity, parity bit 0 -> parity_err=0; same frame with parity bit 1 -> parity_err=1, dout=0xA3.
REQ-035 rx low for 4 ticks then high -> no rx_done, busy returns to 0 within 8 ticks, dout unchanged.
REQ-036 Frame 0xFF with stop bit driven 0 -> rx_done=1, dout=0xFF, frame_err=1.
REQ-037 rst pulsed low during data bit 3 -> all outputs 0 at once, no rx_done; next frame 0x3C received correctly.
REQ-038 Back-to-back frames 0x01 then 0x80 with no idle gap -> two rx_done pulses, dout=0x01 then 0x80, no errors.
